// File: rtl/fan_pwm_tach.sv
// Multi-channel fan controller on Wishbone: PWM outputs with period-boundary
// duty updates, debounced tach counters gated per window, and stall interrupt.

module fpt_tach_ch #(
   parameter int TACH_W = 16,
   parameter int DEB    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tach_i,
   input  logic              last_i,
   output logic [TACH_W-1:0] cnt_next_o,
   output logic [TACH_W-1:0] tach_o
);
   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic              filt_q, filt_d, filt_dly_q, filt_dly_d;
   logic [3:0]        deb_q, deb_d;
   logic [TACH_W-1:0] cnt_q, cnt_d, tach_q, tach_d, cnt_next;
   logic              inc;

   always_comb begin
      sync1_d    = tach_i;
      sync2_d    = sync1_q;
      filt_d     = filt_q;
      filt_dly_d = filt_q;
      deb_d      = '0;
      // Filtered level flips only after DEB consecutive disagreeing samples.
      if (sync2_q != filt_q) begin
         if (deb_q == 4'(DEB - 1)) filt_d = sync2_q;
         else                      deb_d  = deb_q + 1'b1;
      end
      inc      = filt_dly_q & ~filt_q & ~(&cnt_q);
      cnt_next = cnt_q + {{(TACH_W-1){1'b0}}, inc};
      cnt_d    = last_i ? '0 : cnt_next;
      tach_d   = last_i ? cnt_next : tach_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         deb_q      <= '0;
         cnt_q      <= '0;
         tach_q     <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_dly_d;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
         tach_q     <= tach_d;
      end
   end

   assign cnt_next_o = cnt_next;
   assign tach_o     = tach_q;
endmodule

module fan_pwm_tach #(
   parameter int NCH      = 4,
   parameter int PWM_W    = 10,
   parameter int TACH_W   = 16,
   parameter int GATE_CNT = 50000000,
   parameter int DEB      = 4
) (
   input  logic           CLK_I,
   input  logic           RST_I,
   input  logic           FPT_CYC_I,
   input  logic           FPT_STB_I,
   input  logic           FPT_WE_I,
   input  logic [5:0]     FPT_ADR_I,
   input  logic [31:0]    FPT_DAT_I,
   input  logic [3:0]     FPT_SEL_I,
   output logic           FPT_ACK_O,
   output logic           FPT_ERR_O,
   output logic           FPT_RTY_O,
   output logic [31:0]    FPT_DAT_O,
   output logic [NCH-1:0] PWM_O,
   input  logic [NCH-1:0] TACH_I,
   output logic           IRQ_O
);
   localparam int GW = $clog2(GATE_CNT);

   logic                          ack_q, ack_d;
   logic [31:0]                   dat_q, dat_d, rdata;
   logic [NCH-1:0]                ch_en_q, ch_en_d, ie_q, ie_d, stall_q, stall_d;
   logic [NCH-1:0]                w1c, stall_set;
   logic [PWM_W-1:0]              period_sh_q, period_sh_d, period_act_q, period_act_d;
   logic [PWM_W-1:0]              cnt_q, cnt_d;
   logic [NCH-1:0][PWM_W-1:0]     duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
   logic [TACH_W-1:0]             stallth_q, stallth_d;
   logic [GW-1:0]                 gate_q, gate_d;
   logic                          irq_q, irq_d;
   logic                          acc, wr, last, wrap;
   logic [3:0]                    idx;
   logic [NCH-1:0][TACH_W-1:0]    win_cnt, tach_val;
   logic                          unused_ok;

   assign last = (gate_q == GW'(GATE_CNT - 1));

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      fpt_tach_ch #(.TACH_W(TACH_W), .DEB(DEB)) u_ch (
         .clk        (CLK_I),
         .rst        (RST_I),
         .tach_i     (TACH_I[g]),
         .last_i     (last),
         .cnt_next_o (win_cnt[g]),
         .tach_o     (tach_val[g])
      );
      assign stall_set[g] = last & ch_en_q[g] & (win_cnt[g] < stallth_q);
      assign PWM_O[g]     = ch_en_q[g] & (cnt_q < duty_act_q[g]);
   end

   always_comb begin
      acc         = FPT_STB_I & ~ack_q;
      wr          = acc & FPT_WE_I;
      idx         = FPT_ADR_I[5:2];
      ack_d       = acc;
      ch_en_d     = ch_en_q;
      ie_d        = ie_q;
      period_sh_d = period_sh_q;
      stallth_d   = stallth_q;
      duty_sh_d   = duty_sh_q;
      w1c         = '0;
      if (wr) begin
         case (idx)
            4'd0: begin
               ch_en_d = FPT_DAT_I[NCH-1:0];
               ie_d    = FPT_DAT_I[16 +: NCH];
            end
            4'd1: w1c         = FPT_DAT_I[NCH-1:0];
            4'd2: period_sh_d = FPT_DAT_I[PWM_W-1:0];
            4'd3: stallth_d   = FPT_DAT_I[TACH_W-1:0];
            default: ;
         endcase
         for (int i = 0; i < NCH; i++)
            if (idx == 4'(4 + i)) duty_sh_d[i] = FPT_DAT_I[PWM_W-1:0];
      end

      rdata = '0;
      case (idx)
         4'd0: begin
            rdata[NCH-1:0]  = ch_en_q;
            rdata[16 +: NCH] = ie_q;
         end
         4'd1: rdata[NCH-1:0]    = stall_q;
         4'd2: rdata[PWM_W-1:0]  = period_sh_q;
         4'd3: rdata[TACH_W-1:0] = stallth_q;
         default: begin
            for (int i = 0; i < NCH; i++) begin
               if (idx == 4'(4 + i)) rdata[PWM_W-1:0]  = duty_sh_q[i];
               if (idx == 4'(8 + i)) rdata[TACH_W-1:0] = tach_val[i];
            end
         end
      endcase
      dat_d = (acc & ~FPT_WE_I) ? rdata : '0;

      // Active values only change on the wrap cycle so no runt pulses appear.
      wrap         = (cnt_q == period_act_q);
      cnt_d        = wrap ? '0 : cnt_q + 1'b1;
      period_act_d = wrap ? period_sh_q : period_act_q;
      duty_act_d   = wrap ? duty_sh_q : duty_act_q;

      gate_d  = last ? '0 : gate_q + 1'b1;
      stall_d = (stall_q & ~w1c) | stall_set;
      irq_d   = |(stall_q & ie_q);
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ack_q        <= 1'b0;
         dat_q        <= '0;
         ch_en_q      <= '0;
         ie_q         <= '0;
         stall_q      <= '0;
         period_sh_q  <= '1;
         period_act_q <= '1;
         duty_sh_q    <= '0;
         duty_act_q   <= '0;
         stallth_q    <= '0;
         cnt_q        <= '0;
         gate_q       <= '0;
         irq_q        <= 1'b0;
      end else begin
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         ch_en_q      <= ch_en_d;
         ie_q         <= ie_d;
         stall_q      <= stall_d;
         period_sh_q  <= period_sh_d;
         period_act_q <= period_act_d;
         duty_sh_q    <= duty_sh_d;
         duty_act_q   <= duty_act_d;
         stallth_q    <= stallth_d;
         cnt_q        <= cnt_d;
         gate_q       <= gate_d;
         irq_q        <= irq_d;
      end
   end

   assign FPT_ACK_O = ack_q;
   assign FPT_DAT_O = dat_q;
   assign FPT_ERR_O = 1'b0;
   assign FPT_RTY_O = 1'b0;
   assign IRQ_O     = irq_q;
   assign unused_ok = ^{FPT_CYC_I, FPT_SEL_I, FPT_ADR_I[1:0], FPT_DAT_I};
endmodule

// File: tb/tb_fan_pwm_tach.sv
// Directed bench for fan_pwm_tach: bus reads checked through a scoreboard
// queue, PWM duty patterns, tach windows, stall interrupt and mid-window reset.

module tb_fan_pwm_tach;
   localparam int GATE = 1000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        stb, we, tach0;
   logic [5:0]  adr;
   logic [31:0] dat_w, dat_o;
   logic [3:0]  sel;
   logic        ack, err, rty, irq;
   logic [3:0]  pwm;

   int checks = 0, errors = 0;
   int gate_m;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;
   sb_t sb[$];

   fan_pwm_tach #(.NCH(4), .PWM_W(10), .TACH_W(16), .GATE_CNT(GATE), .DEB(4)) dut (
      .CLK_I     (clk),
      .RST_I     (rst),
      .FPT_CYC_I (stb),
      .FPT_STB_I (stb),
      .FPT_WE_I  (we),
      .FPT_ADR_I (adr),
      .FPT_DAT_I (dat_w),
      .FPT_SEL_I (sel),
      .FPT_ACK_O (ack),
      .FPT_ERR_O (err),
      .FPT_RTY_O (rty),
      .FPT_DAT_O (dat_o),
      .PWM_O     (pwm),
      .TACH_I    ({3'b111, tach0}),
      .IRQ_O     (irq)
   );

   always #5 clk = ~clk;

   // Reference window position, tracked independently of the DUT.
   always @(posedge clk)
      if (rst) gate_m <= 0;
      else     gate_m <= (gate_m == GATE - 1) ? 0 : gate_m + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] idx, input logic [31:0] d);
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b1; adr = {idx, 2'b00}; dat_w = d;
      @(posedge clk); #1;
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] idx, input logic [31:0] exp, input string tag);
      int  n;
      sb_t e;
      sb.push_back('{tag, exp});
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b0; adr = {idx, 2'b00};
      n = 0;
      do begin
         step(1);
         n++;
      end while (ack !== 1'b1 && n < 4);
      chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
      e = sb.pop_front();
      chk(e.tag, dat_o, e.exp);
      stb = 1'b0;
   endtask

   task automatic wait_gate(input int target);
      int n;
      n = 0;
      while (gate_m != target && n < 2100) begin
         step(1);
         n++;
      end
      chk("gate_wait", {31'b0, gate_m == target}, 32'd1);
   endtask

   task automatic pulses(input int n, input bit glitch);
      for (int k = 0; k < n; k++)
         for (int c = 0; c < 40; c++) begin
            tach0 = (c >= 20) ^ (glitch && (c == 8 || c == 9 || c == 28 || c == 29));
            step(1);
         end
      tach0 = 1'b1;
   endtask

   task automatic pwm_sum(input int n, output int s);
      s = 0;
      for (int k = 0; k < n; k++) begin
         s += int'(pwm[0]);
         step(1);
      end
   endtask

   initial begin
      int  s;
      bit  found;
      logic prev;
      stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = 4'hf; tach0 = 1'b1;

      // Reset defaults
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pwm", {28'b0, pwm}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      bus_rd(4'd0, 32'd0, "ctrl");
      bus_rd(4'd1, 32'd0, "stat");
      bus_rd(4'd2, 32'h3ff, "period");
      bus_rd(4'd3, 32'd0, "stallth");
      for (int i = 0; i < 4; i++) bus_rd(4'(4 + i), 32'd0, $sformatf("duty%0d", i));
      for (int i = 0; i < 4; i++) bus_rd(4'(8 + i), 32'd0, $sformatf("tach%0d", i));
      bus_rd(4'd15, 32'd0, "idx15");
      step(1);
      chk("ack_fall", {31'b0, ack}, 32'd0);
      chk("dat_idle", dat_o, 32'd0);

      // PWM duty
      bus_wr(4'd2, 32'd9);
      bus_wr(4'd4, 32'd3);
      bus_wr(4'd0, 32'd1);
      step(1100);
      pwm_sum(30, s);
      chk("pwm_3of10", s, 32'd9);
      found = 1'b0;
      prev  = pwm[0];
      for (int k = 0; k < 30 && !found; k++) begin
         step(1);
         if (prev == 1'b0 && pwm[0] == 1'b1) found = 1'b1;
         prev = pwm[0];
      end
      chk("pwm_align", {31'b0, found}, 32'd1);
      bus_wr(4'd4, 32'd7);
      pwm_sum(8, s);
      chk("pwm_old_finish", s, 32'd1);
      pwm_sum(10, s);
      chk("pwm_7of10", s, 32'd7);
      bus_wr(4'd4, 32'd0);
      step(25);
      pwm_sum(20, s);
      chk("pwm_duty0", s, 32'd0);
      bus_wr(4'd4, 32'd12);
      bus_rd(4'd4, 32'd12, "duty0_rb");
      step(25);
      pwm_sum(20, s);
      chk("pwm_duty12", s, 32'd20);
      bus_wr(4'd0, 32'd0);
      chk("pwm_en_off", {31'b0, pwm[0]}, 32'd0);

      // Tach count, clean then glitched
      wait_gate(GATE - 1);
      step(1);
      pulses(25, 1'b0);
      bus_rd(4'd8, 32'd25, "tach_clean");
      pulses(25, 1'b1);
      bus_rd(4'd8, 32'd25, "tach_glitch");

      // Stall interrupt
      bus_wr(4'd3, 32'd30);
      bus_wr(4'd0, 32'h0001_0001);
      wait_gate(GATE - 1);
      chk("irq_pre", {31'b0, irq}, 32'd0);
      step(2);
      chk("irq_set", {31'b0, irq}, 32'd1);
      bus_rd(4'd1, 32'd1, "stat_set");
      bus_wr(4'd1, 32'd1);
      chk("irq_w1c_1", {31'b0, irq}, 32'd1);
      step(1);
      chk("irq_w1c_2", {31'b0, irq}, 32'd0);
      bus_rd(4'd1, 32'd0, "stat_clr");
      pulses(25, 1'b0);
      chk("irq_reset", {31'b0, irq}, 32'd1);
      bus_rd(4'd1, 32'd1, "stat_again");
      bus_rd(4'd8, 32'd25, "tach_stall");

      // W1C on the window-end cycle: set wins
      wait_gate(GATE - 2);
      bus_wr(4'd1, 32'd1);
      bus_rd(4'd1, 32'd1, "stat_race");

      // Reset mid-window
      wait_gate(GATE - 1);
      step(1);
      pulses(10, 1'b0);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("mrst_pwm", {28'b0, pwm}, 32'd0);
      chk("mrst_irq", {31'b0, irq}, 32'd0);
      chk("mrst_ack", {31'b0, ack}, 32'd0);
      chk("mrst_dat", dat_o, 32'd0);
      bus_rd(4'd1, 32'd0, "mrst_stat");
      bus_rd(4'd8, 32'd0, "mrst_tach");
      step(20);
      pulses(12, 1'b0);
      wait_gate(GATE - 1);
      step(2);
      bus_rd(4'd8, 32'd12, "tach_post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fan_pwm_tach.md
# fan_pwm_tach

Multi-channel fan controller on the Wishbone peripheral bus. It generalises the single PWM output and single fan-speed counter into NCH channels. Each channel has a PWM duty register that updates glitch-free at period boundaries, a debounced tachometer pulse counter, and stall detection with a maskable interrupt. It sits beside the existing TWI/GPIO peripheral, with its own address decode.

## Interface
- NCH, 4: channel count, 1..4.
- PWM_W, 10: PWM counter/duty/period width, 4..16.
- TACH_W, 16: tach count width, 8..27.
- GATE_CNT, 50000000: clocks per measurement window (1 s at 50 MHz), ≥ 16.
- DEB, 4: debounce length in clocks, 1..15.
- CLK_I  in  1  system clock; the single clock for the whole block.
- RST_I  in  1  reset; synchronous, active-high.
- FPT_CYC_I  in  1  unused.
- FPT_STB_I  in  1  strobe.
- FPT_WE_I  in  1  1 = write.
- FPT_ADR_I  in  6  byte address; register index = ADR[5:2].
- FPT_DAT_I  in  32  write data.
- FPT_SEL_I  in  4  ignored; all writes are full-word.
- FPT_ACK_O  out  1  acknowledge.
- FPT_ERR_O, FPT_RTY_O  out  1  constant 0.
- FPT_DAT_O  out  32  read data.
- PWM_O  out  NCH  fan PWM outputs.
- TACH_I  in  NCH  asynchronous tach inputs.
- IRQ_O  out  1  stall interrupt, level.

## Operation
- Register map (index):
  - 0 CTRL: [NCH-1:0] ch_en; [16+NCH-1:16] stall_ie. Reset 0.
  - 1 STAT: [NCH-1:0] stall flags. Write-1-to-clear. Reset 0.
  - 2 PERIOD: [PWM_W-1:0]. Reset all-ones.
  - 3 STALLTH: [TACH_W-1:0]. Reset 0.
  - 4+i DUTY[i]: [PWM_W-1:0]. Reset 0. Readback returns the written (pending) value.
  - 8+i TACH[i]: read-only; last window count, zero-extended.
- Unmapped indices: reads return 0; writes are ignored.
- Bus: ACK rises the cycle after STB while ACK=0, and falls the next cycle. Back-to-back STB therefore gives ACK every other cycle.
- Register access:
  - Writes commit on the STB & ~ACK cycle.
  - FPT_DAT_O is registered. It is valid only while ACK=1 and is 0 otherwise.
- PWM:
  - One shared counter cnt runs 0..period_act, then wraps to 0.
  - PWM_O[i] = ch_en[i] & (cnt < duty_act[i]).
  - duty=0 gives constant low; duty > period gives constant high.
  - DUTY and PERIOD writes go to shadow registers. They load into duty_act/period_act on the cycle cnt wraps to 0, so no runt pulses occur.
  - Clearing ch_en[i] forces PWM_O[i] low the next cycle. It does not disturb cnt.
- Tach path, per channel:
  - 2-flop synchroniser, then a debounce counter. The filtered level changes only after the synchronised input differs from it for DEB consecutive clocks.
  - A falling edge of the filtered level increments cnt_i. cnt_i saturates at all-ones.
- Window:
  - Free-running gate counter runs 0..GATE_CNT-1.
  - On the last cycle: TACH[i] ← cnt_i plus any edge in that same cycle; cnt_i ← 0.
  - On the last cycle, if ch_en[i] and the latched value < STALLTH, stall[i] ← 1.
  - Disabled channels still count but never flag a stall.
- IRQ_O = |(stall & stall_ie), registered.
- Simultaneous stall set and W1C clear on the same bit: set wins.

## Timing
- Reset (synchronous, one edge) sets:
  - cnt, gate counter, cnt_i, debounce state, TACH[i], stall to 0.
  - PWM_O = 0, IRQ_O = 0, ACK = 0, DAT_O = 0.
  - period_act all-ones, duty_act 0.
- Reset mid-window discards the partial count. The next window is a full GATE_CNT cycles.
- Write-to-effect latency:
  - CTRL: the cycle after the commit edge.
  - DUTY/PERIOD: at the next wrap. A write on the wrap cycle itself takes effect at the following wrap.
- Tach edge to count: 2 sync cycles + DEB cycles + 1.
- Stall set to IRQ_O: 1 cycle. W1C to IRQ_O low: 2 cycles after commit.
- Gate counter wrap-around: GATE_CNT-1 → 0 with no idle cycle.

## Test plan
- Reset defaults: after reset, read every register. Expect CTRL=0, PERIOD=0x3FF, DUTY=0, TACH=0, STAT=0, index 15 = 0. PWM_O=0, IRQ_O=0.
- PWM duty: PERIOD=9, DUTY0=3, ch_en=1. Expect PWM_O[0] high 3 of every 10 clocks. Write DUTY0=7 mid-period: the old duty completes the period, then 7/10. DUTY0=0 gives constant low; DUTY0=12 gives constant high.
- Tach count: GATE_CNT=1000, DEB=4. Drive 25 clean pulses of 20 low / 20 high clocks per window. Expect TACH0=25. Add 2-clock glitches: count unchanged.
- Stall IRQ: STALLTH=30, stall_ie0=1, ch_en0=1, 25 pulses per window. Expect STAT[0]=1 and IRQ_O=1 one cycle after the window end. W1C STAT=1: IRQ_O low 2 cycles later, then set again at the next window end.
- Set/clear race: issue W1C on the exact window-end cycle with the count below threshold. Expect stall remains 1.
- Reset mid-window: assert RST_I for one clock after 10 pulses. Expect all outputs 0. The next TACH0 reflects only pulses after reset.
